conv_mac_engine: RTL and testbench
==================================

Name: conv_mac_engine

Overview:
- Parametrised multiply-accumulate engine for the LeNet5 convolution datapath.
- Each accepted beat carries LANES signed fixed-point products.
- Accumulates beats over a runtime-configurable window length, starting from a bias term.
- At window end: rounds, rescales to input Q-format, saturates, optionally applies ReLU, and presents one result on a valid/ready output. Feeds the pooling stage directly.

Parameters:
- DATA_W, 17: signed input/output width (Q12.4 at default).
- FRAC_W, 4: fractional bits of inputs, bias and output; must be ≥1.
- LANES, 4: parallel products summed per beat.
- LEN_W, 12: width of cfg_len; max window = 2^LEN_W-1 beats.
- ACC_W, 48: signed accumulator width; must be ≥ 2*DATA_W + LEN_W + clog2(LANES).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous abort of current window/result.
- cfg_len, input, LEN_W: beats per window; sampled on first beat of a window.
- cfg_relu, input, 1: ReLU enable; sampled on first beat.
- bias, input, DATA_W: signed bias, Q-format of inputs; sampled on first beat.
- in_valid, input, 1: beat valid.
- in_ready, output, 1: engine can accept a beat.
- in_a, input, LANES*DATA_W: signed operands; lane i at [i*DATA_W +: DATA_W].
- in_b, input, LANES*DATA_W: signed weights, same packing.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts result.
- out_data, output, DATA_W: signed result, Q-format of inputs.
- out_sat, output, 1: result was clipped by saturation.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset (async): state = IDLE; accumulator, beat counter, out_data, out_sat, out_valid, busy all 0; in_ready = 1 after release.
- Beat accept condition: in_valid & in_ready. Beat sum S = sum over lanes of in_a[i]*in_b[i], full-precision signed, 2*FRAC_W fractional bits, sign-extended to ACC_W.
- Bias extension: bias_ext = sign-extended bias << FRAC_W, aligned to 2*FRAC_W fractional bits.
- States:
  - IDLE: in_ready = 1. On accept, latch len = max(cfg_len, 1), latch relu = cfg_relu, acc <= bias_ext + S, cnt <= 1. Go to OUT if len == 1, else ACCUM.
  - ACCUM: in_ready = 1. On accept, acc <= acc + S and cnt <= cnt + 1. Go to OUT if cnt + 1 == len. With no beat, hold.
  - OUT: in_ready = 0, out_valid = 1. On out_ready, go to IDLE with out_valid = 0 the next cycle.
- Result formation happens in the same clock edge that accepts the final beat, so out_data is registered:
  - r = (acc_final + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift, round-half-up).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat = 1 iff clipped.
  - If relu and result < 0, out_data = 0. out_sat keeps the pre-ReLU value.
- Latency: out_valid rises on the cycle after the final beat is accepted.
- Throughput: one result per len+1 cycles when out_ready is held high.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_sat are held stable and no beat is accepted.
- Window gaps: in_valid deasserted mid-window simply stalls; there is no timeout.
- cfg_len, cfg_relu and bias changes after the first beat have no effect until the next window.
- flush: has priority over all beat and output activity in that cycle. Next cycle: state = IDLE, acc = 0, cnt = 0, out_valid = 0; any pending result is discarded. out_data keeps its last value.
- Reset mid-window: all state cleared immediately. The next accepted beat starts a new window.
- Accumulator width rule: no accumulator overflow is possible within parameter constraints. Saturation applies only at the output.

Test Plan:
- LANES=1, cfg_len=3, bias=0, relu=0; three beats a=16 (1.0), b=32 (2.0) -> acc=1536; out_data=96 (6.0), out_sat=0. out_valid rises 1 cycle after the 3rd beat.
- Rounding, len=1, bias=0, a=1, b=8 -> acc=8; out_data=1. Repeat with bias=16 (1.0) -> out_data=17.
- Sign/ReLU, len=1, a=16, b=-32: relu=0 -> out_data=-32; relu=1 -> out_data=0, out_sat=0.
- Saturation, len=2, a=b=65535 on lane 0 -> out_data=65535, out_sat=1. a=65535, b=-65535 -> out_data=-65536, out_sat=1.
- Back-pressure and gaps, len=4 with in_valid gaps between beats, out_ready=0 for 5 cycles:
  - out_valid stays high and out_data stays constant; in_ready=0 throughout.
  - First beat of the next window is accepted the cycle after out_ready=1.
  - cfg_len=0 behaves as 1.
- Abort, len=5: assert flush after 2 beats, and separately assert reset after 3 beats -> busy=0, out_valid=0. A fresh window of 2 beats of 16*16 with bias=0 then gives out_data=32, with no residue from the aborted window.

Source files
------------

// File: rtl/conv_mac_engine_if.sv
// Beat and result handshake bundle for conv_mac_engine.
// The master side feeds beats and drains results; the engine is the slave.
interface conv_mac_engine_if #(
    parameter int DATA_W = 17,
    parameter int LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [DATA_W-1:0]  out_data;
    logic                      out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Windowed multiply-accumulate with bias, round-half-up rescale, saturation
// and optional ReLU; one registered result per window.
module conv_mac_engine #(
    parameter int DATA_W = 17,
    parameter int FRAC_W = 4,
    parameter int LANES  = 4,
    parameter int LEN_W  = 12,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_relu,
    input  logic signed [DATA_W-1:0] bias,
    conv_mac_engine_if.slave         bus,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    localparam logic signed [ACC_W-1:0]  HALF    = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, OUT_MAX};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W){1'b1}}, OUT_MIN};

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic [LEN_W-1:0]          cnt_q, len_q;
    logic                      relu_q;
    logic signed [DATA_W-1:0]  out_data_q;
    logic                      out_sat_q;

    logic                      accept, last_beat, relu_now;
    logic [LEN_W-1:0]          eff_len;
    logic signed [DATA_W-1:0]  lane_a, lane_b;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   beat_sum, bias_ext, acc_base, acc_sum;
    logic signed [ACC_W-1:0]   rounded, scaled;
    logic signed [DATA_W-1:0]  result;
    logic                      clipped;

    assign bus.in_ready  = (state_q != OUT);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign busy          = (state_q != IDLE);

    assign accept   = bus.in_valid & bus.in_ready;
    assign eff_len  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;
    assign acc_base = (state_q == IDLE) ? bias_ext : acc_q;
    assign acc_sum  = acc_base + beat_sum;
    assign relu_now = (state_q == IDLE) ? cfg_relu : relu_q;
    assign last_beat = (state_q == IDLE) ? (eff_len == LEN_W'(1))
                                         : ((cnt_q + LEN_W'(1)) == len_q);

    always_comb begin
        beat_sum = '0;
        lane_a   = '0;
        lane_b   = '0;
        prod     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_a   = bus.in_a[i*DATA_W +: DATA_W];
            lane_b   = bus.in_b[i*DATA_W +: DATA_W];
            prod     = lane_a * lane_b;
            beat_sum = beat_sum + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    // Result is formed from the sum that includes the final beat, so the
    // output register is loaded on the same edge that accepts that beat.
    always_comb begin
        rounded = acc_sum + HALF;
        scaled  = rounded >>> FRAC_W;
        clipped = 1'b0;
        result  = scaled[DATA_W-1:0];
        if (scaled > SAT_MAX) begin
            result  = OUT_MAX;
            clipped = 1'b1;
        end else if (scaled < SAT_MIN) begin
            result  = OUT_MIN;
            clipped = 1'b1;
        end
        if (relu_now && result[DATA_W-1])
            result = '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (accept) state_d = last_beat ? OUT : ACCUM;
            OUT:         if (bus.out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (flush) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            acc_q <= acc_sum;
            if (state_q == IDLE) begin
                cnt_q  <= LEN_W'(1);
                len_q  <= eff_len;
                relu_q <= cfg_relu;
            end else begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
            if (last_beat) begin
                out_data_q <= result;
                out_sat_q  <= clipped;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed vector bench for conv_mac_engine: table of windows plus
// back-pressure, flush and reset sequences.
module tb_conv_mac_engine;
    localparam int DATA_W = 17;
    localparam int FRAC_W = 4;
    localparam int LANES  = 4;
    localparam int LEN_W  = 12;
    localparam int ACC_W  = 48;
    localparam int NVEC   = 11;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [LEN_W-1:0]         cfg_len;
    logic                     cfg_relu;
    logic signed [DATA_W-1:0] bias;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    conv_mac_engine_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    conv_mac_engine #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES), .LEN_W(LEN_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .cfg_len(cfg_len),
        .cfg_relu(cfg_relu), .bias(bias), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    len;
        bit    relu;
        int    bias;
        int    a[LANES];
        int    b[LANES];
        int    nbeats;
        int    exp_data;
        bit    exp_sat;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_lanes(input int a[LANES], input int b[LANES]);
        logic [LANES*DATA_W-1:0] pa, pb;
        for (int i = 0; i < LANES; i++) begin
            pa[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
            pb[i*DATA_W +: DATA_W] = DATA_W'(b[i]);
        end
        bus.in_a = pa;
        bus.in_b = pb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, "_drained"}, bus.out_valid, 0);
    endtask

    task automatic run_vec(input vec_t v);
        set_lanes(v.a, v.b);
        cfg_len      = LEN_W'(v.len);
        cfg_relu     = v.relu;
        bias         = DATA_W'(v.bias);
        bus.in_valid = 1'b1;
        for (int i = 0; i < v.nbeats; i++) begin
            check({v.name, "_no_early_valid"}, bus.out_valid, 0);
            step();
        end
        bus.in_valid = 1'b0;
        check({v.name, "_valid"}, bus.out_valid, 1);
        check({v.name, "_data"}, longint'($signed(bus.out_data)), v.exp_data);
        check({v.name, "_sat"}, bus.out_sat, v.exp_sat);
        drain(v.name);
    endtask

    task automatic simple_window(input int len, input int a0, input int b0, input int bs);
        int a[LANES];
        int b[LANES];
        a = '{default: 0};
        b = '{default: 0};
        a[0] = a0;
        b[0] = b0;
        set_lanes(a, b);
        cfg_len  = LEN_W'(len);
        cfg_relu = 1'b0;
        bias     = DATA_W'(bs);
    endtask

    initial begin
        vecs[0]  = '{"basic3",    3, 0,   0, '{16, 0, 0, 0},     '{32, 0, 0, 0},      3,     96, 0};
        vecs[1]  = '{"round",     1, 0,   0, '{1, 0, 0, 0},      '{8, 0, 0, 0},       1,      1, 0};
        vecs[2]  = '{"round_b",   1, 0,  16, '{1, 0, 0, 0},      '{8, 0, 0, 0},       1,     17, 0};
        vecs[3]  = '{"neg",       1, 0,   0, '{16, 0, 0, 0},     '{-32, 0, 0, 0},     1,    -32, 0};
        vecs[4]  = '{"relu",      1, 1,   0, '{16, 0, 0, 0},     '{-32, 0, 0, 0},     1,      0, 0};
        vecs[5]  = '{"sat_pos",   2, 0,   0, '{65535, 0, 0, 0},  '{65535, 0, 0, 0},   2,  65535, 1};
        vecs[6]  = '{"sat_neg",   2, 0,   0, '{65535, 0, 0, 0},  '{-65535, 0, 0, 0},  2, -65536, 1};
        vecs[7]  = '{"len0",      0, 0,   0, '{16, 0, 0, 0},     '{16, 0, 0, 0},      1,     16, 0};
        vecs[8]  = '{"lanes4",    2, 0, -16, '{16, 32, -16, 48}, '{16, 16, 16, 16},   2,    144, 0};
        vecs[9]  = '{"neg_round", 1, 0,   0, '{-1, 0, 0, 0},     '{9, 0, 0, 0},       1,     -1, 0};
        vecs[10] = '{"relu_sat",  2, 1,   0, '{65535, 0, 0, 0},  '{-65535, 0, 0, 0},  2,      0, 1};

        reset         = 1'b1;
        flush         = 1'b0;
        cfg_len       = '0;
        cfg_relu      = 1'b0;
        bias          = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rst_in_ready", bus.in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure with gapped beats; config changes mid-window must be ignored.
        simple_window(4, 16, 16, 0);
        for (int beat = 0; beat < 4; beat++) begin
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            if (beat == 0) begin
                cfg_len = LEN_W'(1);
                bias    = DATA_W'(100);
            end
            if (beat < 3) begin
                step();
                step();
                check("gap_busy", busy, 1);
                check("gap_no_valid", bus.out_valid, 0);
            end
        end
        check("bp_valid", bus.out_valid, 1);
        check("bp_data", longint'($signed(bus.out_data)), 64);
        simple_window(1, 16, 16, 0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_data", longint'($signed(bus.out_data)), 64);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_busy", busy, 0);
        check("bp_release_data", longint'($signed(bus.out_data)), 64);
        step();
        bus.in_valid = 1'b0;
        check("next_accept_valid", bus.out_valid, 1);
        check("next_accept_data", longint'($signed(bus.out_data)), 16);
        drain("next_accept");

        // Flush after two beats of a five-beat window.
        simple_window(5, 100, 100, 50);
        bus.in_valid = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_valid", bus.out_valid, 0);
        check("flush_keep_data", longint'($signed(bus.out_data)), 16);
        simple_window(2, 16, 16, 0);
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        check("post_flush_valid", bus.out_valid, 1);
        check("post_flush_data", longint'($signed(bus.out_data)), 32);

        // Flush while a result is pending discards it.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_out_busy", busy, 0);
        check("flush_out_data", longint'($signed(bus.out_data)), 32);

        // Asynchronous reset after three beats of a five-beat window.
        simple_window(5, 100, 100, 50);
        bus.in_valid = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        #2;
        bus.in_valid = 1'b0;
        check("areset_busy", busy, 0);
        check("areset_valid", bus.out_valid, 0);
        check("areset_data", bus.out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        simple_window(2, 16, 16, 0);
        bus.in_valid = 1'b1;
        step();
        check("post_reset_busy", busy, 1);
        step();
        bus.in_valid = 1'b0;
        check("post_reset_valid", bus.out_valid, 1);
        check("post_reset_data", longint'($signed(bus.out_data)), 32);
        check("post_reset_sat", bus.out_sat, 0);
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
